// File: rtl/lzc_stream.sv
// Streaming leading-zero counter over WORDS x WIDTH frames, MSB word first.
// Optional LZC_ONES_EN adds count_ones to count leading ones instead.
module lzc_stream #(
    parameter  int WIDTH = 8,
    parameter  int WORDS = 4,
    localparam int CW    = $clog2(WIDTH * WORDS) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef LZC_ONES_EN
    input  logic             count_ones,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_zeros,
    output logic             out_allzero
);

    localparam int WCW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [WCW-1:0] LASTW = WCW'(WORDS - 1);
    localparam logic [CW-1:0]  FULL  = CW'(WIDTH * WORDS);

    typedef enum logic [1:0] {IDLE, ACC, HOLD, DRAIN} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_live;
    logic [WCW-1:0]   r_wcnt;
    logic [CW-1:0]    r_acc;
    logic [CW-1:0]    r_zeros;
    logic             r_allz;
    logic             r_found;
    logic             r_fmode;
    logic             r_pend;

    logic             w_first;
    logic             w_last;
    logic             w_fmode;
    logic             w_take;
    logic             w_nz;
    logic             w_decide;
    logic [WIDTH-1:0] w_data;
    logic [CW-1:0]    w_lz;
    logic [CW-1:0]    w_acc_nxt;
    logic [WCW-1:0]   w_wcnt_inc;

    assign w_first    = (r_wcnt == '0);
    assign w_last     = (r_wcnt == LASTW);
    assign w_fmode    = w_first ? mode : r_fmode;
    assign w_wcnt_inc = w_last ? '0 : r_wcnt + WCW'(1);

`ifdef LZC_ONES_EN
    logic r_ones;
    logic w_ones;
    assign w_ones = w_first ? count_ones : r_ones;
    assign w_data = in_data ^ {WIDTH{w_ones}};
`else
    assign w_data = in_data;
`endif

    // Ascending scan: the highest set bit is the last one to write w_lz
    always_comb begin
        w_lz = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (w_data[i]) w_lz = CW'(WIDTH - 1 - i);
        end
    end

    assign w_nz      = (w_lz != CW'(WIDTH));
    assign w_acc_nxt = r_found ? r_acc : r_acc + w_lz;
    assign in_ready  = r_live && (r_state != HOLD);
    assign w_take    = in_valid && in_ready;
    assign w_decide  = w_last || (w_fmode && w_nz);

    assign out_valid   = (r_state == HOLD);
    assign out_zeros   = r_zeros;
    assign out_allzero = r_allz;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, ACC: if (w_take) w_next = w_decide ? HOLD : ACC;
            HOLD:      if (out_ready) w_next = r_pend ? DRAIN : IDLE;
            DRAIN:     if (w_take && w_last) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live  <= 1'b0;
            r_wcnt  <= '0;
            r_acc   <= '0;
            r_zeros <= '0;
            r_allz  <= 1'b0;
            r_found <= 1'b0;
            r_fmode <= 1'b0;
            r_pend  <= 1'b0;
`ifdef LZC_ONES_EN
            r_ones  <= 1'b0;
`endif
        end else begin
            r_live <= 1'b1;
            unique case (r_state)
                IDLE, ACC: begin
                    if (w_take) begin
                        r_wcnt  <= w_wcnt_inc;
                        r_acc   <= w_acc_nxt;
                        r_found <= r_found | w_nz;
                        if (w_first) r_fmode <= mode;
`ifdef LZC_ONES_EN
                        if (w_first) r_ones <= count_ones;
`endif
                        if (w_decide) begin
                            r_zeros <= w_acc_nxt;
                            r_allz  <= (w_acc_nxt == FULL);
                            r_pend  <= w_fmode && w_nz && !w_last;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_acc   <= '0;
                        r_found <= 1'b0;
                        r_pend  <= 1'b0;
                        if (!r_pend) r_wcnt <= '0;
                    end
                end
                DRAIN: begin
                    if (w_take) r_wcnt <= w_wcnt_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lzc_stream.sv
// Directed self-checking bench for lzc_stream, WIDTH=8 WORDS=4.
// Build with LZC_ONES_EN defined to also exercise count_ones.
module tb_lzc_stream;

    localparam int WIDTH = 8;
    localparam int WORDS = 4;
    localparam int CW    = $clog2(WIDTH * WORDS) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             mode = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CW-1:0]    out_zeros;
    logic             out_allzero;
    logic             c1 = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lzc_stream #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef LZC_ONES_EN
        .count_ones (c1),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_zeros  (out_zeros),
        .out_allzero(out_allzero)
    );

    task automatic send(input logic [7:0] d, input logic m);
        int n = 0;
        while (!in_ready && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_wait in_ready=%b want 1", in_ready);
        end
        in_data  = d;
        mode     = m;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        if (out_zeros !== 6'd0) begin errors++; $display("FAIL rst_zeros got %0d want 0", out_zeros); end
        if (out_allzero !== 1'b0) begin errors++; $display("FAIL rst_allzero got %b want 0", out_allzero); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_normal();
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h10, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL normal_early valid got %b want 0", out_valid); end
        send(8'hFF, 1'b0);
        checks += 4;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL normal_valid got %b want 1", out_valid); end
        if (out_zeros !== 6'd19) begin errors++; $display("FAIL normal_zeros got %0d want 19", out_zeros); end
        if (out_allzero !== 1'b0) begin errors++; $display("FAIL normal_allzero got %b want 0", out_allzero); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL normal_hold_ready got %b want 0", in_ready); end
        handshake();
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL normal_after valid got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL normal_after ready got %b want 1", in_ready); end
    endtask

    task automatic test_turbo();
        send(8'h00, 1'b1);
        send(8'h00, 1'b1);
        send(8'h10, 1'b1);
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL turbo_valid got %b want 1", out_valid); end
        if (out_zeros !== 6'd19) begin errors++; $display("FAIL turbo_zeros got %0d want 19", out_zeros); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL turbo_hold_ready got %b want 0", in_ready); end
        handshake();
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL turbo_drain valid got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL turbo_drain ready got %b want 1", in_ready); end
        send(8'hFF, 1'b1);
        repeat (3) begin
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL turbo_no_second got %b want 0", out_valid); end
            @(posedge clk); #1;
        end
        send(8'h20, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL turbo_next valid got %b want 1", out_valid); end
        if (out_zeros !== 6'd2) begin errors++; $display("FAIL turbo_next zeros got %0d want 2", out_zeros); end
        handshake();
    endtask

    task automatic test_allzero();
        for (int m = 0; m < 2; m++) begin
            for (int w = 0; w < 3; w++) send(8'h00, m[0]);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL allzero_early m=%0d got %b want 0", m, out_valid); end
            send(8'h00, m[0]);
            checks += 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL allzero_valid m=%0d got %b want 1", m, out_valid); end
            if (out_zeros !== 6'd32) begin errors++; $display("FAIL allzero_zeros m=%0d got %0d want 32", m, out_zeros); end
            if (out_allzero !== 1'b1) begin errors++; $display("FAIL allzero_flag m=%0d got %b want 1", m, out_allzero); end
            handshake();
        end
    endtask

    task automatic test_back_to_back();
        send(8'h03, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        for (int c = 0; c < 5; c++) begin
            checks += 4;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c=%0d got %b want 1", c, out_valid); end
            if (out_zeros !== 6'd6) begin errors++; $display("FAIL stall_zeros c=%0d got %0d want 6", c, out_zeros); end
            if (out_allzero !== 1'b0) begin errors++; $display("FAIL stall_allzero c=%0d got %b want 0", c, out_allzero); end
            if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready c=%0d got %b want 0", c, in_ready); end
            @(posedge clk); #1;
        end
        handshake();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", in_ready); end
        send(8'h80, 1'b0);
        send(8'hAA, 1'b0);
        send(8'h00, 1'b0);
        send(8'h55, 1'b0);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", out_valid); end
        if (out_zeros !== 6'd0) begin errors++; $display("FAIL b2b_zeros got %0d want 0", out_zeros); end
        handshake();
    endtask

    task automatic test_mode_toggle();
        send(8'h00, 1'b0);
        send(8'h40, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL toggle_n_early got %b want 0", out_valid); end
        send(8'h00, 1'b1);
        send(8'h00, 1'b1);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL toggle_n_valid got %b want 1", out_valid); end
        if (out_zeros !== 6'd9) begin errors++; $display("FAIL toggle_n_zeros got %0d want 9", out_zeros); end
        handshake();
        send(8'h00, 1'b1);
        send(8'h40, 1'b0);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL toggle_t_valid got %b want 1", out_valid); end
        if (out_zeros !== 6'd9) begin errors++; $display("FAIL toggle_t_zeros got %0d want 9", out_zeros); end
        handshake();
        send(8'hFF, 1'b0);
        send(8'hFF, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL toggle_t_drain got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b want 0", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid); end
        if (out_zeros !== 6'd0) begin errors++; $display("FAIL midrst_zeros got %0d want 0", out_zeros); end
        if (out_allzero !== 1'b0) begin errors++; $display("FAIL midrst_allzero got %b want 0", out_allzero); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(8'h01, 1'b0);
        send(8'hFF, 1'b0);
        send(8'h00, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_early got %b want 0", out_valid); end
        send(8'h00, 1'b0);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_after valid got %b want 1", out_valid); end
        if (out_zeros !== 6'd7) begin errors++; $display("FAIL midrst_after zeros got %0d want 7", out_zeros); end
        handshake();
    endtask

`ifdef LZC_ONES_EN
    task automatic test_ones();
        c1 = 1'b1;
        send(8'hFF, 1'b0);
        c1 = 1'b0;
        send(8'hF0, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL ones_valid got %b want 1", out_valid); end
        if (out_zeros !== 6'd12) begin errors++; $display("FAIL ones_zeros got %0d want 12", out_zeros); end
        if (out_allzero !== 1'b0) begin errors++; $display("FAIL ones_allzero got %b want 0", out_allzero); end
        handshake();
    endtask
`endif

    initial begin
        test_reset();
        test_normal();
        test_turbo();
        test_allzero();
        test_back_to_back();
        test_mode_toggle();
        test_reset_mid();
`ifdef LZC_ONES_EN
        test_ones();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lzc_stream.md
# lzc_stream

Streaming, parametrised leading-zero counter that measures the leading zeros of a frame of `WORDS` words, each `WIDTH` bits, delivered MSB-word first over a valid/ready input channel. Generalises the earlier single-width LZC with configurable width and depth, full input/output back-pressure, frame-aligned turbo (early-exit) mode and an all-zero flag. Sits between a word-serial datapath source and a normalisation/shift consumer.

## Interface
- `WIDTH`, 8, bits per input word; legal range is 2 or more.
- `WORDS`, 4, words per frame; legal range is 1 or more.
- `CW`, `$clog2(WIDTH*WORDS)+1`, result width; derived, not overridden.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  block accepts a word this cycle.
- `in_data`  in  WIDTH  input word; bit WIDTH-1 is most significant.
- `mode`  in  1  0 = normal, 1 = turbo; sampled with the first word of a frame.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer takes the result.
- `out_zeros`  out  CW  leading-zero count of the frame, 0..WIDTH*WORDS.
- `out_allzero`  out  1  the whole frame was zero, so `out_zeros`==WIDTH*WORDS.

## Operation
- A word is accepted on a cycle with `in_valid && in_ready`.
- A word counter `wcnt` (0..WORDS-1) increments on each accept and wraps to 0 after word WORDS-1.
- Per-word leading-zero count `lz`: priority encode from the MSB; `lz`=WIDTH if the word is 0.
- The accumulator adds `lz` while no one has been found yet in the frame. The first nonzero word sets `found`, and the accumulator is frozen after that add.
- `mode` is latched as `fmode` on the word with `wcnt`==0. Changes on `mode` during the rest of the frame are ignored.
- States:
  - IDLE: `in_ready`=1. On accept, go to ACC; if WORDS==1 or the word completes the result, go straight to HOLD.
  - ACC: `in_ready`=1, accumulating.
  - HOLD: `out_valid`=1, `in_ready`=0.
  - DRAIN: `in_ready`=1, discarding the remainder of a turbo frame.
- Normal mode: accept of word WORDS-1 → HOLD.
- Turbo mode, on accept of the first nonzero word:
  - if it is word WORDS-1 → HOLD;
  - otherwise → HOLD with `drain_pend`=1.
- Turbo mode with an all-zero frame ends on word WORDS-1, the same as normal mode.
- HOLD on `out_ready`:
  - if `drain_pend` is set → DRAIN;
  - otherwise → IDLE, with the accumulator, `found` and `wcnt` cleared.
- DRAIN: accept the remaining words without using them; accept of word WORDS-1 → IDLE with everything cleared. No second result is produced.
- `out_allzero` = (`out_zeros`==WIDTH*WORDS). The accumulator is CW bits wide and cannot overflow.

## Timing
- Reset value of all outputs: `in_ready`=0 while `rst_n` is low and 1 from the first cycle after release; `out_valid`=0, `out_zeros`=0, `out_allzero`=0. State is IDLE and all counters are 0.
- Latency: `out_valid` rises on the cycle after the accept of the deciding word. The deciding word is the last word (normal mode) or the first nonzero word (turbo mode).
- `out_zeros` and `out_allzero` are registered and stay stable while `out_valid`=1 and `out_ready`=0.
- HOLD lasts at least one cycle. Because `in_ready` is 0 in HOLD, an input accept and an output handshake never happen on the same cycle.
- Back-to-back frames: the cycle after the output handshake, IDLE (or DRAIN) accepts the next word. Throughput is WORDS+1 cycles per normal frame.
- `rst_n` asserted mid-frame or in HOLD/DRAIN: immediate return to reset values. A partial frame is discarded, and the next accepted word is treated as word 0.

## Configuration
- `LZC_ONES_EN` defined:
  - adds input `count_ones` (1 bit), latched with `mode` on word 0;
  - when the latched value is 1, the block counts leading ones: data is inverted before the encoder, and `out_allzero` then means all ones.
- `LZC_ONES_EN` undefined: the `count_ones` port is absent and the block counts leading zeros only.

## Test plan
All scenarios use WIDTH=8, WORDS=4.
- Normal mode, frame 0x00,0x00,0x10,0xFF → `out_zeros`=19, `out_allzero`=0, `out_valid` one cycle after the 4th accept.
- Turbo mode, same frame → `out_zeros`=19 one cycle after the 3rd accept, with `in_ready`=0 in HOLD. After the handshake the 4th word is drained, there is no second `out_valid`, and the next frame's word 0 is counted correctly.
- Normal mode, all-zero frame → `out_zeros`=32, `out_allzero`=1. Turbo mode, all-zero frame → same result after the 4th word.
- `out_ready` held low 5 cycles in HOLD → `out_valid` and the data stay stable and `in_ready`=0. On release, a back-to-back frame 0x80,x,x,x in normal mode → 0.
- `mode` toggled mid-frame → ignored. `rst_n` pulsed after 2 accepts → all outputs 0; the following frame 0x01,... gives 7.
- `LZC_ONES_EN` build, `count_ones`=1, frame 0xFF,0xF0,0x00,0x00 → `out_zeros`=12.
